// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator with PC-relative
// target. Results are registered with one-cycle latency. A 2-entry skid
// buffer (output register + skid register) lets in_ready be a plain flop.
// Optional feature macro: IMM_GEN_ILLEGAL_EN adds the out_illegal flag.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit RST_READY = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
`ifdef IMM_GEN_ILLEGAL_EN
    output logic            out_illegal,
`endif
    output logic [XLEN-1:0] out_target
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        fmt_e            fmt;
`ifdef IMM_GEN_ILLEGAL_EN
        logic            illegal;
`endif
    } entry_t;

    entry_t      dec;
    entry_t      out_q;
    entry_t      skid_q;
    logic        skid_valid;
    logic [31:0] imm32;
    fmt_e        fmt_d;

    logic accept, handoff, out_free;
    logic out_valid_n, skid_valid_n;
    logic load_out_dec, load_out_skid, load_skid;

    // Immediate decode: every format fits in 32 bits, so build a 32-bit
    // sign-extended value and widen it; this gives U-type its bit-31
    // extension on RV64 for free.
    always_comb begin
        imm32 = '0;
        fmt_d = FMT_NONE;
        case (in_inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                fmt_d = FMT_I;
            end
            OP_STORE: begin
                imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                fmt_d = FMT_S;
            end
            OP_BRANCH: begin
                imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                         in_inst[30:25], in_inst[11:8], 1'b0};
                fmt_d = FMT_B;
            end
            OP_JAL: begin
                imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                         in_inst[20], in_inst[30:21], 1'b0};
                fmt_d = FMT_J;
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {in_inst[31:12], 12'h000};
                fmt_d = FMT_U;
            end
            default: begin
                imm32 = '0;
                fmt_d = FMT_NONE;
            end
        endcase
    end

    // Pack the decoded entry; target is formed for every format, NONE included.
    always_comb begin
        dec        = '0;
        dec.inst   = in_inst;
        dec.pc     = in_pc;
        dec.imm    = XLEN'($signed(imm32));
        dec.target = in_pc + XLEN'($signed(imm32));
        dec.fmt    = fmt_d;
`ifdef IMM_GEN_ILLEGAL_EN
        // All eight opcodes end in 2'b11, so an exact 7-bit opcode miss
        // already covers the compressed-encoding case.
        dec.illegal = (fmt_d == FMT_NONE);
`endif
    end

    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;
    assign out_free = !out_valid || handoff;

    // Skid control. An accept never coincides with skid_valid because
    // in_ready is exactly !skid_valid, so the skid slot never overflows.
    always_comb begin
        out_valid_n   = out_valid;
        skid_valid_n  = skid_valid;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                load_out_skid = 1'b1;
                out_valid_n   = 1'b1;
                skid_valid_n  = 1'b0;
            end else if (accept) begin
                load_out_dec = 1'b1;
                out_valid_n  = 1'b1;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    // Valid flags and the registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= RST_READY;
        end else begin
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            in_ready   <= !skid_valid_n;
        end
    end

    // Data registers only move on a load, keeping held outputs stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_skid)     out_q <= skid_q;
            else if (load_out_dec) out_q <= dec;
            if (load_skid)         skid_q <= dec;
        end
    end

    assign out_imm    = out_q.imm;
    assign out_fmt    = out_q.fmt;
    assign out_inst   = out_q.inst;
    assign out_pc     = out_q.pc;
    assign out_target = out_q.target;
`ifdef IMM_GEN_ILLEGAL_EN
    assign out_illegal = out_q.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share one
// input stream and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        r32, v32, r64, v64;
    logic [31:0] imm32, inst32, pc32, tgt32;
    logic [63:0] imm64, pc64, tgt64;
    logic [31:0] inst64;
    logic [2:0]  fmt32, fmt64;
`ifdef IMM_GEN_ILLEGAL_EN
    logic        ill32, ill64;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } item_t;

    item_t q[$];
    bit    m_ready;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .RST_READY(1'b1)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .flush(flush),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_inst(inst32), .out_pc(pc32),
`ifdef IMM_GEN_ILLEGAL_EN
        .out_illegal(ill32),
`endif
        .out_target(tgt32)
    );

    imm_gen_pipe #(.XLEN(64), .RST_READY(1'b1)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_inst(inst64), .out_pc(pc64),
`ifdef IMM_GEN_ILLEGAL_EN
        .out_illegal(ill64),
`endif
        .out_target(tgt64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate as a signed integer, from the ISA field weights.
    function automatic void ref_dec(input logic [31:0] i, output longint imm, output int fmt);
        longint v;
        v = 0;
        fmt = 0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: begin
                fmt = 1;
                v = longint'(i[31:20]);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                fmt = 2;
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                fmt = 3;
                v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                  + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h6F: begin
                fmt = 5;
                v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                  + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            7'h37, 7'h17: begin
                fmt = 4;
                v = longint'(i[31:12]) * 4096;
                if (v >= 64'sh80000000) v -= 64'sh100000000;
            end
            default: begin
                fmt = 0;
                v = 0;
            end
        endcase
        imm = v;
    endfunction

    task automatic check_all();
        longint      imm;
        int          fmt;
        logic [63:0] e64, t64;
        logic [31:0] t32;
        chk("valid32", 64'(v32), 64'(q.size() > 0));
        chk("ready32", 64'(r32), 64'(m_ready));
        chk("valid64", 64'(v64), 64'(q.size() > 0));
        chk("ready64", 64'(r64), 64'(m_ready));
        if (q.size() > 0) begin
            ref_dec(q[0].inst, imm, fmt);
            e64 = 64'(imm);
            t64 = q[0].pc + e64;
            t32 = q[0].pc[31:0] + e64[31:0];
            chk("imm32", 64'(imm32), 64'(e64[31:0]));
            chk("fmt32", 64'(fmt32), 64'(fmt));
            chk("inst32", 64'(inst32), 64'(q[0].inst));
            chk("pc32", 64'(pc32), 64'(q[0].pc[31:0]));
            chk("tgt32", 64'(tgt32), 64'(t32));
            chk("imm64", imm64, e64);
            chk("fmt64", 64'(fmt64), 64'(fmt));
            chk("inst64", 64'(inst64), 64'(q[0].inst));
            chk("pc64", pc64, q[0].pc);
            chk("tgt64", tgt64, t64);
`ifdef IMM_GEN_ILLEGAL_EN
            chk("ill32", 64'(ill32), 64'(fmt == 0));
            chk("ill64", 64'(ill64), 64'(fmt == 0));
`endif
        end
    endtask

    // Drive one cycle from a negedge, update the model at the posedge,
    // then check at the following negedge.
    task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                        input bit ordy, input bit fl, input bit r);
        bit acc, hand;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ready = 1'b1;
        end else if (fl) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            acc  = v && m_ready;
            hand = (q.size() > 0) && ordy;
            if (hand) void'(q.pop_front());
            if (acc) q.push_back('{inst: inst, pc: pc});
            m_ready = (q.size() < 2);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] r, op_pick;
        logic [6:0]  ops [8];
        logic [63:0] rpc;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; m_ready = 1'b1;
        @(negedge clk);
        step(0, 32'h0, 64'h0, 0, 0, 1);
        step(0, 32'h0, 64'h0, 0, 0, 1);
        chk("rst_imm32", 64'(imm32), 64'h0);
        chk("rst_fmt32", 64'(fmt32), 64'h0);
        chk("rst_inst32", 64'(inst32), 64'h0);
        chk("rst_pc64", pc64, 64'h0);
        chk("rst_tgt64", tgt64, 64'h0);
`ifdef IMM_GEN_ILLEGAL_EN
        chk("rst_ill32", 64'(ill32), 64'h0);
`endif

        // addi x1,x0,-1
        step(1, 32'hFFF00093, 64'h0, 1, 0, 0);
        chk("t1_imm", 64'(imm32), 64'hFFFFFFFF);
        chk("t1_fmt", 64'(fmt32), 64'd1);
        chk("t1_tgt", 64'(tgt32), 64'hFFFFFFFF);
        // sw x2,-4(x1)
        step(1, 32'hFE20AE23, 64'h0, 1, 0, 0);
        chk("t2_imm", 64'(imm32), 64'hFFFFFFFC);
        chk("t2_fmt", 64'(fmt32), 64'd2);
        // beq -8 at 0x100, then jal +2048
        step(1, 32'hFE000CE3, 64'h100, 1, 0, 0);
        chk("t3_imm", 64'(imm32), 64'hFFFFFFF8);
        chk("t3_fmt", 64'(fmt32), 64'd3);
        chk("t3_tgt", 64'(tgt32), 64'h000000F8);
        step(1, 32'h0010006F, 64'h100, 1, 0, 0);
        chk("t3j_imm", 64'(imm32), 64'h00000800);
        chk("t3j_fmt", 64'(fmt32), 64'd5);
        // lui x1,0x80000 on RV64 sign-extends from bit 31
        step(1, 32'h800000B7, 64'h0, 1, 0, 0);
        chk("t6_imm64", imm64, 64'hFFFFFFFF80000000);
        // all-zero word is unknown
        step(1, 32'h00000000, 64'h40, 1, 0, 0);
        chk("t6_fmt0", 64'(fmt32), 64'd0);
`ifdef IMM_GEN_ILLEGAL_EN
        chk("t6_ill", 64'(ill32), 64'd1);
`endif
        step(0, 32'h0, 64'h0, 1, 0, 0);

        // Backpressure: A, B, C with out_ready low
        step(1, 32'h00A00093, 64'h10, 0, 0, 0);
        step(1, 32'h00B00113, 64'h14, 0, 0, 0);
        chk("t4_full_rdy", 64'(r32), 64'd0);
        step(1, 32'h00C00193, 64'h18, 0, 0, 0);
        chk("t4_hold_A", 64'(inst32), 64'h00A00093);
        step(1, 32'h00C00193, 64'h18, 1, 0, 0);
        chk("t4_out_B", 64'(inst32), 64'h00B00113);
        step(1, 32'h00C00193, 64'h18, 1, 0, 0);
        chk("t4_out_C", 64'(inst32), 64'h00C00193);
        step(0, 32'h0, 64'h0, 1, 0, 0);
        chk("t4_drained", 64'(v32), 64'd0);

        // Flush with both entries full and a new offer in the same cycle
        step(1, 32'h00100093, 64'h20, 0, 0, 0);
        step(1, 32'h00200093, 64'h24, 0, 0, 0);
        step(1, 32'h00300093, 64'h28, 0, 1, 0);
        chk("t5_valid", 64'(v32), 64'd0);
        chk("t5_ready", 64'(r32), 64'd1);
        step(0, 32'h0, 64'h0, 1, 0, 0);
        chk("t5_none", 64'(v64), 64'd0);

        // Randomized stream
        for (int n = 0; n < 2000; n++) begin
            r       = $urandom();
            op_pick = $urandom_range(0, 9);
            rpc     = {$urandom(), $urandom()};
            step(($urandom_range(0, 9) < 7),
                 {r[31:7], (op_pick < 8) ? ops[op_pick[2:0]] : r[6:0]},
                 rpc,
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 199) < 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It takes an instruction and its PC over a valid/ready handshake, decodes the RV32I/RV64I immediate for all base formats, and computes the PC-relative target. It returns registered results with one-cycle latency through a 2-entry skid buffer. It sits between instruction fetch/IF-ID and the decode/execute stage, and absorbs execute-side backpressure without a combinational in_ready path.

Parameters:
XLEN, 32, datapath width for imm/pc/target; legal values 32 or 64; immediates are sign-extended to XLEN.
RST_READY, 1, reset value of in_ready (1 = accept input on the first cycle after reset).

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream offers inst/pc
in_ready  output  1  block can accept; registered (equals !skid_valid)
in_inst  input  32  instruction word
in_pc  input  XLEN  instruction address
flush  input  1  synchronous kill of all held entries
out_valid  output  1  result available
out_ready  input  1  downstream accepts
out_imm  output  XLEN  decoded, sign-extended byte-offset immediate
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
out_inst  output  32  instruction passthrough
out_pc  output  XLEN  PC passthrough
out_target  output  XLEN  out_pc + out_imm, mod 2^XLEN

Behaviour:
- Decode by inst[6:0]:
  - I-type (0010011, 0000011, 1100111): imm = sext(inst[31:20]).
  - S-type (0100011): imm = sext({inst[31:25], inst[11:7]}). This is a signed value.
  - B-type (1100011): imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}). This is a true byte offset; the execute stage must not apply an extra shift.
  - J-type (1101111): imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - U-type (0110111, 0010111): imm = sext({inst[31:12], 12'h000}). For XLEN=64 this sign-extends from bit 31.
  - Any other opcode: imm = 0, fmt = NONE.
- out_target is computed for every format, including NONE. The consumer decides whether to use it.
- Storage is an output register (out_valid) plus a skid register (skid_valid). Neither is visible as an extra port.
- Accept occurs when in_valid && in_ready. Handoff occurs when out_valid && out_ready.
- Latency is 1 cycle. An input accepted at cycle N appears on out_* at N+1 when the output register is empty or handed off at N.
- If the output register is held (out_valid && !out_ready) when an accept occurs, the entry goes to the skid register and in_ready falls the next cycle.
- On handoff with skid_valid set, the skid entry moves to the output register; in_ready rises the next cycle.
- Order is strictly preserved. There is no bubble when both sides are streaming; throughput is 1 per cycle.
- While out_valid && !out_ready, all out_* fields stay stable.
- Flush: at the next edge, out_valid = 0, skid_valid = 0, and in_ready = 1. Any input accepted in the flush cycle is discarded. Flush has priority over accept and handoff in the same cycle.
- Reset state: out_valid = 0, skid_valid = 0, out_imm/out_fmt/out_inst/out_pc/out_target = 0, in_ready = RST_READY. Inputs are ignored while rst is high. Reset mid-stream discards both entries.
- No data registers change when nothing is accepted or moved.
- XLEN values other than 32/64 are a configuration error; flag them with an elaboration-time check.

Optional Feature:
Macro IMM_GEN_ILLEGAL_EN.
- Defined: adds port out_illegal (output, 1), registered alongside the other fields and reset to 0. It is 1 when inst[1:0] != 2'b11 or the opcode is not among the eight listed. In that case out_imm = 0, out_fmt = NONE, and the entry still flows through the handshake normally.
- Not defined: the port is absent, and unknown opcodes simply produce NONE / imm 0.

Test Plan:
1. XLEN=32; in_inst=0xFFF00093 (addi x1,x0,-1), pc=0, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_target=0xFFFFFFFF.
2. in_inst=0xFE20AE23 (sw x2,-4(x1)) -> out_imm=0xFFFFFFFC, out_fmt=2. This checks S-type sign extension.
3. in_inst=0xFE000CE3 (beq -8), pc=0x100 -> out_imm=0xFFFFFFF8, out_fmt=3, out_target=0x000000F8. Then in_inst=0x0010006F (jal +2048) -> out_imm=0x00000800, out_fmt=5.
4. Backpressure: out_ready=0, push three instructions A, B, C back-to-back.
   - A is held on out_*, B is in skid, in_ready=0, and C waits.
   - Raise out_ready: outputs A, B, C in order on consecutive handoffs, with no loss or duplication.
5. Flush with both entries full and in_valid=1 in the same cycle -> next cycle out_valid=0 and in_ready=1. None of the three entries ever appears.
6. XLEN=64; in_inst=0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000. With IMM_GEN_ILLEGAL_EN, inst=0x00000000 -> out_illegal=1, out_fmt=0.
